// File: rtl/recepcao_serial_pixels_pkg.sv
// rtl/recepcao_serial_pixels_pkg.sv - shared state encodings, debug codes and baud constant
package recepcao_serial_pixels_pkg;

  localparam int CLKS_PER_BIT_115200 = 434;

  localparam logic [3:0] ST_INICIAL    = 4'd0;
  localparam logic [3:0] ST_PREPARACAO = 4'd1;
  localparam logic [3:0] ST_ESPERA_MSB = 4'd2;
  localparam logic [3:0] ST_ESPERA_LSB = 4'd3;
  localparam logic [3:0] ST_ESCREVE    = 4'd4;
  localparam logic [3:0] ST_CONTA      = 4'd5;
  localparam logic [3:0] ST_FIM        = 4'd6;

  localparam logic [3:0] DB_INICIAL    = 4'b0000;
  localparam logic [3:0] DB_PREPARACAO = 4'b0001;
  localparam logic [3:0] DB_ESPERA_MSB = 4'b0010;
  localparam logic [3:0] DB_ESPERA_LSB = 4'b0011;
  localparam logic [3:0] DB_ESCREVE    = 4'b0100;
  localparam logic [3:0] DB_CONTA      = 4'b0101;
  localparam logic [3:0] DB_FIM        = 4'b0110;
  localparam logic [3:0] DB_INVALIDO   = 4'b1110;

  function automatic logic [3:0] db_code(input logic [3:0] st);
    case (st)
      ST_INICIAL:    db_code = DB_INICIAL;
      ST_PREPARACAO: db_code = DB_PREPARACAO;
      ST_ESPERA_MSB: db_code = DB_ESPERA_MSB;
      ST_ESPERA_LSB: db_code = DB_ESPERA_LSB;
      ST_ESCREVE:    db_code = DB_ESCREVE;
      ST_CONTA:      db_code = DB_CONTA;
      ST_FIM:        db_code = DB_FIM;
      default:       db_code = DB_INVALIDO;
    endcase
  endfunction

endpackage

// File: rtl/recepcao_serial_pixels_rx.sv
// rtl/recepcao_serial_pixels_rx.sv - 8N1 byte receiver with synchroniser and mid-bit sampling
module rx_serial_8n1
  import recepcao_serial_pixels_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] dado,
  output logic       dado_valido,
  output logic       erro
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] MEIO = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FIM_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] UM = CW'(1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DADOS = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [2:0]    sync_q, sync_d;
  logic [1:0]    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    nbit_q, nbit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valido_q, valido_d;
  logic          erro_q, erro_d;
  logic          rx_s, queda;

  // sync_q[1] is the synchronised line; sync_q[2] is its previous value for edge detection
  always_comb begin
    sync_d   = {sync_q[1:0], rx};
    rx_s     = sync_q[1];
    queda    = sync_q[2] & ~sync_q[1];
    st_d     = st_q;
    cnt_d    = cnt_q;
    nbit_d   = nbit_q;
    shift_d  = shift_q;
    valido_d = 1'b0;
    erro_d   = 1'b0;
    case (st_q)
      RX_IDLE: begin
        if (queda) begin
          st_d  = RX_START;
          cnt_d = '0;
        end
      end
      RX_START: begin
        if (cnt_q == MEIO) begin
          cnt_d  = '0;
          nbit_d = '0;
          st_d   = rx_s ? RX_IDLE : RX_DADOS;
        end else begin
          cnt_d = cnt_q + UM;
        end
      end
      RX_DADOS: begin
        if (cnt_q == FIM_BIT) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          nbit_d  = nbit_q + 3'd1;
          if (nbit_q == 3'd7) st_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + UM;
        end
      end
      default: begin
        if (cnt_q == FIM_BIT) begin
          cnt_d    = '0;
          st_d     = RX_IDLE;
          valido_d = rx_s;
          erro_d   = ~rx_s;
        end else begin
          cnt_d = cnt_q + UM;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q   <= 3'b111;
      st_q     <= RX_IDLE;
      cnt_q    <= '0;
      nbit_q   <= '0;
      shift_q  <= '0;
      valido_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      nbit_q   <= nbit_d;
      shift_q  <= shift_d;
      valido_q <= valido_d;
      erro_q   <= erro_d;
    end
  end

  assign dado        = shift_q;
  assign dado_valido = valido_q;
  assign erro        = erro_q;

endmodule

// File: rtl/recepcao_serial_pixels.sv
// rtl/recepcao_serial_pixels.sv - pairs received bytes into pixels and writes them in raster order
module recepcao_serial_pixels
  import recepcao_serial_pixels_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int N_COLUNAS    = 160,
  parameter int N_LINHAS     = 120
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         iniciar,
  input  logic                         rx,
  output logic                         escrita,
  output logic [15:0]                  pixel,
  output logic [$clog2(N_LINHAS)-1:0]  linha,
  output logic [$clog2(N_COLUNAS)-1:0] coluna,
  output logic                         ocupado,
  output logic                         pronto,
  output logic                         erro_quadro,
  output logic [3:0]                   db_estado
);

  localparam int LW = $clog2(N_LINHAS);
  localparam int CW = $clog2(N_COLUNAS);
  localparam logic [LW-1:0] LIN_MAX = LW'(N_LINHAS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(N_COLUNAS - 1);
  localparam logic [LW-1:0] LIN_UM  = LW'(1);
  localparam logic [CW-1:0] COL_UM  = CW'(1);

  logic [7:0]    rx_dado;
  logic          rx_valido, rx_erro;
  logic [3:0]    st_q, st_d;
  logic [15:0]   pixel_q, pixel_d;
  logic [LW-1:0] linha_q, linha_d;
  logic [CW-1:0] coluna_q, coluna_d;
  logic          erro_quadro_q, erro_quadro_d;

  rx_serial_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .dado        (rx_dado),
    .dado_valido (rx_valido),
    .erro        (rx_erro)
  );

  always_comb begin
    st_d          = st_q;
    pixel_d       = pixel_q;
    linha_d       = linha_q;
    coluna_d      = coluna_q;
    erro_quadro_d = erro_quadro_q;
    case (st_q)
      ST_INICIAL: if (iniciar) st_d = ST_PREPARACAO;
      ST_PREPARACAO: begin
        linha_d       = '0;
        coluna_d      = '0;
        erro_quadro_d = 1'b0;
        st_d          = ST_ESPERA_MSB;
      end
      ST_ESPERA_MSB: begin
        if (rx_valido) begin
          pixel_d[15:8] = rx_dado;
          st_d          = ST_ESPERA_LSB;
        end else if (rx_erro) begin
          erro_quadro_d = 1'b1;
        end
      end
      ST_ESPERA_LSB: begin
        if (rx_valido) begin
          pixel_d[7:0] = rx_dado;
          st_d         = ST_ESCREVE;
        end else if (rx_erro) begin
          erro_quadro_d = 1'b1;
        end
      end
      ST_ESCREVE: st_d = ST_CONTA;
      ST_CONTA: begin
        if (coluna_q < COL_MAX) begin
          coluna_d = coluna_q + COL_UM;
          st_d     = ST_ESPERA_MSB;
        end else begin
          coluna_d = '0;
          if (linha_q < LIN_MAX) begin
            linha_d = linha_q + LIN_UM;
            st_d    = ST_ESPERA_MSB;
          end else begin
            st_d = ST_FIM;
          end
        end
      end
      ST_FIM: st_d = ST_INICIAL;
      default: st_d = ST_INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      st_q          <= ST_INICIAL;
      pixel_q       <= '0;
      linha_q       <= '0;
      coluna_q      <= '0;
      erro_quadro_q <= 1'b0;
    end else begin
      st_q          <= st_d;
      pixel_q       <= pixel_d;
      linha_q       <= linha_d;
      coluna_q      <= coluna_d;
      erro_quadro_q <= erro_quadro_d;
    end
  end

  assign escrita     = (st_q == ST_ESCREVE);
  assign pronto      = (st_q == ST_FIM);
  assign ocupado     = (st_q >= ST_PREPARACAO) && (st_q <= ST_FIM);
  assign pixel       = pixel_q;
  assign linha       = linha_q;
  assign coluna      = coluna_q;
  assign erro_quadro = erro_quadro_q;
  assign db_estado   = db_code(st_q);

endmodule
